conv_pool: RTL

2x2 max-pooling stage placed directly downstream of the convolution block. Consumes the 16 signed 16-bit results of one 4x4 feature map as a row-major serial stream and emits the 4 pooled maxima (2x2 map) serially, each one cycle after its window completes. Supports back-to-back frames, gaps in the input stream, and an optional ReLU applied to the pooled outputs.

---
 rtl/conv_pool.sv | 75 +++++++
 1 files changed

// File: rtl/conv_pool.sv
// conv_pool: 2x2 signed max-pooling of a row-major serial 4x4 feature map, optional ReLU.
// Latency: each pooled result is registered one cycle after its window's last element.
// Backpressure: none; every in_valid cycle is accepted unconditionally.
module conv_pool #(
  parameter bit RELU = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic signed [15:0] in_data,
  output logic               out_valid,
  output logic signed [15:0] out_data,
  output logic               out_last
);

  // Position of the next element inside the 4x4 frame: pos = {r[1:0], c[1:0]}
  logic        [3:0]  pos;
  // Running max of the current row pair within a window
  logic signed [15:0] tmp;
  // Max of the even-row half of each column pair, read back on the odd row
  logic signed [15:0] part [2];

  logic               row_odd;
  logic               col_odd;
  logic               col_pair;
  logic signed [15:0] pair_max;
  logic signed [15:0] part_max;
  logic signed [15:0] result;

  assign row_odd  = pos[2];
  assign col_odd  = pos[0];
  assign col_pair = pos[1];

  // Signed maxima for each update path plus the optional ReLU clamp on the window result
  always_comb begin
    pair_max = (in_data > tmp) ? in_data : tmp;
    part_max = (in_data > part[col_pair]) ? in_data : part[col_pair];
    result   = pair_max;
    if (RELU && pair_max[15]) begin
      result = '0;
    end
  end

  // Frame position, partial maxima and registered single-cycle output pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos       <= '0;
      tmp       <= '0;
      part[0]   <= '0;
      part[1]   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      if (in_valid) begin
        pos <= pos + 4'd1;
        unique case ({row_odd, col_odd})
          2'b00: tmp            <= in_data;
          2'b01: part[col_pair] <= pair_max;
          2'b10: tmp            <= part_max;
          2'b11: begin
            out_valid <= 1'b1;
            out_data  <= result;
            out_last  <= (pos == 4'd15);
          end
          default: ;
        endcase
      end
    end
  end

endmodule
